// File: rtl/mem_arbiter_if.sv
// Bus bundle between the two requesters (CPU, DMA), the arbiter and the
// single-port memory.
interface mem_arbiter_if;
  logic        CpuReq;
  logic [11:0] CpuAddr;
  logic [3:0]  CpuWMask;
  logic [31:0] CpuWData;
  logic        CpuGnt;
  logic        CpuRValid;
  logic [31:0] CpuRData;

  logic        DmaReq;
  logic [11:0] DmaAddr;
  logic [3:0]  DmaWMask;
  logic [31:0] DmaWData;
  logic        DmaGnt;
  logic        DmaRValid;
  logic [31:0] DmaRData;

  logic        MemEn;
  logic [11:0] MemAddr;
  logic [3:0]  MemWMask;
  logic [31:0] MemWData;
  logic [31:0] MemRData;

  modport slave (
    input  CpuReq, CpuAddr, CpuWMask, CpuWData,
    output CpuGnt, CpuRValid, CpuRData,
    input  DmaReq, DmaAddr, DmaWMask, DmaWData,
    output DmaGnt, DmaRValid, DmaRData,
    output MemEn, MemAddr, MemWMask, MemWData,
    input  MemRData
  );

  modport master (
    output CpuReq, CpuAddr, CpuWMask, CpuWData,
    input  CpuGnt, CpuRValid, CpuRData,
    output DmaReq, DmaAddr, DmaWMask, DmaWData,
    input  DmaGnt, DmaRValid, DmaRData,
    input  MemEn, MemAddr, MemWMask, MemWData,
    output MemRData
  );
endinterface

// File: rtl/mem_arbiter.sv
// Two-requester memory arbiter: CPU priority with a bounded DMA starvation
// window, combinational grant and one-cycle read-data return routing.
//
// state  | meaning
// IDLE   | no read outstanding
// RD_CPU | CPU read granted last cycle, MemRData belongs to CPU
// RD_DMA | DMA read granted last cycle, MemRData belongs to DMA
module mem_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic   Clock,
  input  logic   Reset_n,
  mem_arbiter_if.slave bus
);

  localparam int unsigned CW = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_CPU = 2'd1,
    RD_DMA = 2'd2
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] starve_cnt_q, starve_cnt_d;
  logic          cpu_gnt, dma_gnt;

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q      <= IDLE;
      starve_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

  // Grants are gated by reset so nothing reaches memory while Reset_n is low.
  always_comb begin
    cpu_gnt = 1'b0;
    dma_gnt = 1'b0;
    if (Reset_n) begin
      if (bus.CpuReq && (!bus.DmaReq || starve_cnt_q != LIMIT)) begin
        cpu_gnt = 1'b1;
      end else if (bus.DmaReq) begin
        dma_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    starve_cnt_d = starve_cnt_q;
    if (!bus.DmaReq || dma_gnt) begin
      starve_cnt_d = '0;
    end else if (cpu_gnt && starve_cnt_q != LIMIT) begin
      starve_cnt_d = starve_cnt_q + CW'(1);
    end
  end

  always_comb begin
    state_d = IDLE;
    if (cpu_gnt && bus.CpuWMask == 4'b0000) begin
      state_d = RD_CPU;
    end else if (dma_gnt && bus.DmaWMask == 4'b0000) begin
      state_d = RD_DMA;
    end
  end

  always_comb begin
    bus.CpuGnt   = cpu_gnt;
    bus.DmaGnt   = dma_gnt;
    bus.MemEn    = cpu_gnt | dma_gnt;
    bus.MemAddr  = '0;
    bus.MemWMask = 4'b0000;
    bus.MemWData = '0;
    if (cpu_gnt) begin
      bus.MemAddr  = bus.CpuAddr;
      bus.MemWMask = bus.CpuWMask;
      bus.MemWData = bus.CpuWData;
    end else if (dma_gnt) begin
      bus.MemAddr  = bus.DmaAddr;
      bus.MemWMask = bus.DmaWMask;
      bus.MemWData = bus.DmaWData;
    end
  end

  // Return routing depends only on registered state, so a write granted in
  // the same cycle cannot disturb the returning read.
  always_comb begin
    bus.CpuRValid = (state_q == RD_CPU);
    bus.DmaRValid = (state_q == RD_DMA);
    bus.CpuRData  = (state_q == RD_CPU) ? bus.MemRData : 32'b0;
    bus.DmaRData  = (state_q == RD_DMA) ? bus.MemRData : 32'b0;
  end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter STARVE_LIMIT, default 4: the maximum number of consecutive CPU grants while a DMA request is pending.
REQ-002 The block SHALL have these ports, clock and reset first:
- Clock  in  1  sole clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- CpuReq  in  1  CPU requests an access.
- CpuAddr  in  12  CPU word address.
- CpuWMask  in  4  CPU byte write mask; 4'b0000 means read.
- CpuWData  in  32  CPU write data, already lane-shifted.
- CpuGnt  out  1  CPU request accepted this cycle.
- CpuRValid  out  1  CPU read data valid.
- CpuRData  out  32  CPU read data.
- DmaReq, DmaAddr, DmaWMask, DmaWData, DmaGnt, DmaRValid, DmaRData  same widths and meaning as the Cpu* ports, for the DMA/bootloader requester.
- MemEn  out  1  memory port enable.
- MemAddr  out  12  memory word address.
- MemWMask  out  4  memory byte write enables.
- MemWData  out  32  memory write data.
- MemRData  in  32  memory read data, valid one cycle after the read is issued.
REQ-003 Reset SHALL be asynchronous and active-low on Reset_n, with the single clock Clock.

Function
REQ-004 Each requester SHALL hold Req, Addr, WMask and WData stable from assertion until it samples Gnt high. The arbiter SHALL NOT check this.
REQ-005 Grant SHALL be combinational in the request cycle. At most one of CpuGnt and DmaGnt SHALL be high in any cycle.
REQ-006 When a requester is granted, MemEn SHALL be 1 and MemAddr, MemWMask and MemWData SHALL equal that requester's inputs in the same cycle.
REQ-007 When no requester is granted, MemEn SHALL be 0 and MemWMask SHALL be 4'b0000.
REQ-008 Arbitration SHALL follow these rules:
- Only one requester: that requester is granted.
- Both request: CPU wins, unless StarveCnt equals STARVE_LIMIT, in which case DMA wins.
REQ-009 StarveCnt SHALL be a register of width ceil(log2(STARVE_LIMIT+1)), updated at the clock edge:
- Increment by 1 on a cycle where CPU is granted and DmaReq is 1.
- Clear to 0 on a DMA grant, or on any cycle where DmaReq is 0.
- Otherwise hold, and never exceed STARVE_LIMIT.
REQ-010 Read-return state SHALL be tracked by a 3-state machine:
- IDLE: no read outstanding.
- RD_CPU: a CPU read was granted in the previous cycle.
- RD_DMA: a DMA read was granted in the previous cycle.
REQ-011 The state machine SHALL transition at each clock edge as follows:
- To RD_CPU if a CPU read (WMask==0) is granted this cycle.
- To RD_DMA if a DMA read is granted this cycle.
- Otherwise to IDLE.
REQ-012 The transitions of REQ-011 SHALL apply from every state, so back-to-back reads are accepted every cycle with no bubble.
REQ-013 In RD_CPU, CpuRValid SHALL be 1 and CpuRData SHALL equal MemRData. The same applies to RD_DMA with the Dma* ports. Read latency from Gnt to RValid SHALL be exactly 1 cycle.
REQ-014 RValid SHALL never be asserted for a write. A write SHALL be complete at its Gnt cycle.
REQ-015 RData outputs SHALL be 32'b0 whenever the corresponding RValid is 0.
REQ-016 A write granted in the cycle where a prior read returns SHALL NOT disturb that read's RValid or RData.

Reset
REQ-017 While Reset_n is 0, the following SHALL hold regardless of Clock:
- State = IDLE and StarveCnt = 0.
- CpuGnt, DmaGnt, MemEn, CpuRValid and DmaRValid are 0.
- MemWMask = 4'b0000, and RData outputs are 0.
REQ-018 A read granted in the cycle before Reset_n falls SHALL be discarded, with no RValid after reset release.
REQ-019 Arbitration SHALL resume on the first rising edge after Reset_n returns to 1.

Verification
REQ-020 The bench SHALL cover the following directed scenarios:
- CPU read only: CpuReq=1, CpuAddr=12'h010, CpuWMask=0 -> CpuGnt=1, MemEn=1, MemAddr=12'h010. The next cycle gives CpuRValid=1 and CpuRData equal to the memory word; DmaRValid stays 0.
- CPU write only: CpuReq=1, CpuWMask=4'b0011, CpuWData=32'h0000BEEF -> MemWMask=4'b0011 and MemWData=32'h0000BEEF in the Gnt cycle; no RValid follows.
- Starvation bound: CpuReq and DmaReq both held at 1 with STARVE_LIMIT=4 -> grant pattern C,C,C,C,D, repeating; StarveCnt never exceeds 4.
- DMA drop: DmaReq deasserted mid-stream -> StarveCnt is 0 on the next cycle; CPU is granted every cycle.
- Back-to-back reads: CPU read at addr 1, then DMA read at addr 2 in consecutive cycles -> CpuRValid in cycle t+1 and DmaRValid in cycle t+2, each carrying its own data.
- Reset mid-read: Reset_n pulled low one cycle after a CPU read Gnt -> CpuRValid=0 immediately and stays 0 after release until a new read is granted.
